// File: rtl/jedro_1_dmem_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and the byte-write RAM.
// Lock inputs exist only when JEDRO_1_DMEM_ARB_LOCK_EN is defined.
interface jedro_1_dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  m0_req_i;
  logic [BE_W-1:0]       m0_we_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic [DATA_WIDTH-1:0] m0_wdata_i;
  logic                  m0_gnt_o;
  logic                  m0_rvalid_o;
  logic [DATA_WIDTH-1:0] m0_rdata_o;

  logic                  m1_req_i;
  logic [BE_W-1:0]       m1_we_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic [DATA_WIDTH-1:0] m1_wdata_i;
  logic                  m1_gnt_o;
  logic                  m1_rvalid_o;
  logic [DATA_WIDTH-1:0] m1_rdata_o;

  logic                  ram_en_o;
  logic [BE_W-1:0]       ram_we_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [DATA_WIDTH-1:0] ram_wdata_o;
  logic [DATA_WIDTH-1:0] ram_rdata_i;

`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
  logic                  m0_lock_i;
  logic                  m1_lock_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_lock_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_lock_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_lock_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_lock_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );
`else
  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );
`endif
endinterface

// File: rtl/jedro_1_dmem_arbiter.sv
// Round-robin two-master arbiter for the jedro_1 byte-write data RAM with read-response routing.
// Define JEDRO_1_DMEM_ARB_LOCK_EN to add bounded locked ownership (MAX_LOCK consecutive grants).
module jedro_1_dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 8
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  jedro_1_dmem_arbiter_if.slave   bus
);
  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   rsp_valid_q, rsp_valid_d;
  logic   rsp_id_q, rsp_id_d;
  logic   gnt0, gnt1;
  logic   rr0, rr1;

  logic [BE_W-1:0]       we_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;

`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             hold0, hold1, lock_full;
`else
  localparam int unused_max_lock = MAX_LOCK;
  logic unused_state;
  assign unused_state = (state_q != IDLE);
`endif

  // Grants are combinational and forced low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    rr0  = bus.m0_req_i && (!bus.m1_req_i || last_q);
    rr1  = bus.m1_req_i && (!bus.m0_req_i || !last_q);
`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
    hold0     = (state_q == OWN0) && bus.m0_req_i && bus.m0_lock_i;
    hold1     = (state_q == OWN1) && bus.m1_req_i && bus.m1_lock_i;
    lock_full = (lock_cnt_q >= CNT_W'(MAX_LOCK));
    if (hold0) begin
      gnt1 = lock_full && bus.m1_req_i;
      gnt0 = !gnt1;
    end else if (hold1) begin
      gnt0 = lock_full && bus.m0_req_i;
      gnt1 = !gnt0;
    end else begin
      gnt0 = rr0;
      gnt1 = rr1;
    end
`else
    gnt0 = rr0;
    gnt1 = rr1;
`endif
    gnt0 = gnt0 && rstn_i;
    gnt1 = gnt1 && rstn_i;
  end

  always_comb begin
    state_d     = IDLE;
    last_d      = last_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
    lock_cnt_d  = '0;
`endif
    if (gnt0) begin
      last_d      = 1'b0;
      rsp_valid_d = (bus.m0_we_i == '0);
      rsp_id_d    = rsp_valid_d ? 1'b0 : rsp_id_q;
`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
      if (bus.m0_lock_i) begin
        state_d    = OWN0;
        lock_cnt_d = (state_q != OWN0) ? CNT_W'(1) :
                     lock_full ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
      end
`else
      state_d     = OWN0;
`endif
    end else if (gnt1) begin
      last_d      = 1'b1;
      rsp_valid_d = (bus.m1_we_i == '0);
      rsp_id_d    = rsp_valid_d ? 1'b1 : rsp_id_q;
`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
      if (bus.m1_lock_i) begin
        state_d    = OWN1;
        lock_cnt_d = (state_q != OWN1) ? CNT_W'(1) :
                     lock_full ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
      end
`else
      state_d     = OWN1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  // RAM side: granted master's fields, everything zero when idle.
  always_comb begin
    we_sel    = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    if (gnt0) begin
      we_sel    = bus.m0_we_i;
      addr_sel  = bus.m0_addr_i;
      wdata_sel = bus.m0_wdata_i;
    end else if (gnt1) begin
      we_sel    = bus.m1_we_i;
      addr_sel  = bus.m1_addr_i;
      wdata_sel = bus.m1_wdata_i;
    end
  end

  assign bus.ram_en_o    = gnt0 || gnt1;
  assign bus.ram_we_o    = we_sel;
  assign bus.ram_addr_o  = addr_sel;
  assign bus.ram_wdata_o = wdata_sel;

  assign bus.m0_gnt_o    = gnt0;
  assign bus.m1_gnt_o    = gnt1;
  assign bus.m0_rvalid_o = rsp_valid_q && !rsp_id_q;
  assign bus.m1_rvalid_o = rsp_valid_q && rsp_id_q;
  assign bus.m0_rdata_o  = bus.m0_rvalid_o ? bus.ram_rdata_i : '0;
  assign bus.m1_rdata_o  = bus.m1_rvalid_o ? bus.ram_rdata_i : '0;
endmodule

// File: tb/tb_jedro_1_dmem_arbiter.sv
// Directed bench for jedro_1_dmem_arbiter: a transaction-level reference model plus a
// byte-write RAM emulation, compared against the DUT every cycle, with literal pins.
module tb_jedro_1_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int ML = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  jedro_1_dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  jedro_1_dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Byte-write RAM, word indexed, one cycle read latency.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ram_q;
  assign bus.ram_rdata_i = ram_q;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= '0;
    mem[1] <= 32'hA0A0_0004;
    mem[2] <= 32'hB0B0_0008;
    mem[3] <= 32'hC0C0_000C;
    mem[4] <= 32'hDEAD_BEEF;
    ram_q  <= '0;
  end

  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      ram_q <= mem[bus.ram_addr_o[9:2]];
      for (int b = 0; b < BW; b++)
        if (bus.ram_we_o[b]) mem[bus.ram_addr_o[9:2]][b*8 +: 8] <= bus.ram_wdata_o[b*8 +: 8];
    end
  end

  // Reference model: who owns the RAM this cycle and which read is outstanding.
  bit            m_last;
  bit            m_pend;
  bit            m_pend_id;
  logic [DW-1:0] m_pend_data;
  int            m_own;
  int            m_cnt;

  function automatic void model_gnt(output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rstn) return;
`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
    if (m_own == 1 && bus.m0_req_i && bus.m0_lock_i) begin
      if (m_cnt >= ML && bus.m1_req_i) g1 = 1'b1; else g0 = 1'b1;
      return;
    end
    if (m_own == 2 && bus.m1_req_i && bus.m1_lock_i) begin
      if (m_cnt >= ML && bus.m0_req_i) g0 = 1'b1; else g1 = 1'b1;
      return;
    end
`endif
    if (bus.m0_req_i && bus.m1_req_i) begin
      if (m_last) g0 = 1'b1; else g1 = 1'b1;
    end else begin
      g0 = bus.m0_req_i;
      g1 = bus.m1_req_i;
    end
  endfunction

  always @(posedge clk or negedge rstn) begin : model_upd
    bit g0, g1;
    if (!rstn) begin
      m_last = 1'b1;
      m_pend = 1'b0;
      m_own  = 0;
      m_cnt  = 0;
    end else begin
      model_gnt(g0, g1);
      m_pend = 1'b0;
      if (g0) begin
        m_last = 1'b0;
        if (bus.m0_we_i == '0) begin
          m_pend = 1'b1; m_pend_id = 1'b0; m_pend_data = mem[bus.m0_addr_i[9:2]];
        end
      end else if (g1) begin
        m_last = 1'b1;
        if (bus.m1_we_i == '0) begin
          m_pend = 1'b1; m_pend_id = 1'b1; m_pend_data = mem[bus.m1_addr_i[9:2]];
        end
      end
`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
      if (g0 && bus.m0_lock_i) begin
        m_cnt = (m_own == 1) ? ((m_cnt < ML) ? m_cnt + 1 : m_cnt) : 1;
        m_own = 1;
      end else if (g1 && bus.m1_lock_i) begin
        m_cnt = (m_own == 2) ? ((m_cnt < ML) ? m_cnt + 1 : m_cnt) : 1;
        m_own = 2;
      end else begin
        m_own = 0;
        m_cnt = 0;
      end
`endif
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    bit            g0, g1;
    logic [BW-1:0] e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit            rv0, rv1;
    model_gnt(g0, g1);
    e_we = '0; e_addr = '0; e_wdata = '0;
    if (g0) begin
      e_we = bus.m0_we_i; e_addr = bus.m0_addr_i; e_wdata = bus.m0_wdata_i;
    end else if (g1) begin
      e_we = bus.m1_we_i; e_addr = bus.m1_addr_i; e_wdata = bus.m1_wdata_i;
    end
    rv0 = m_pend && !m_pend_id;
    rv1 = m_pend && m_pend_id;
    check("m0_gnt", bus.m0_gnt_o, g0);
    check("m1_gnt", bus.m1_gnt_o, g1);
    check("ram_en", bus.ram_en_o, g0 | g1);
    check("ram_we", bus.ram_we_o, e_we);
    check("ram_addr", bus.ram_addr_o, e_addr);
    check("ram_wdata", bus.ram_wdata_o, e_wdata);
    check("m0_rvalid", bus.m0_rvalid_o, rv0);
    check("m1_rvalid", bus.m1_rvalid_o, rv1);
    check("m0_rdata", bus.m0_rdata_o, rv0 ? m_pend_data : '0);
    check("m1_rdata", bus.m1_rdata_o, rv1 ? m_pend_data : '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m0_req_i = 1'b0; bus.m0_we_i = '0; bus.m0_addr_i = '0; bus.m0_wdata_i = '0;
    bus.m1_req_i = 1'b0; bus.m1_we_i = '0; bus.m1_addr_i = '0; bus.m1_wdata_i = '0;
`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
    bus.m0_lock_i = 1'b0;
    bus.m1_lock_i = 1'b0;
`endif
  endtask

  task automatic set_m0(input logic [BW-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.m0_req_i = 1'b1; bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_wdata_i = wd;
  endtask

  task automatic set_m1(input logic [BW-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.m1_req_i = 1'b1; bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_wdata_i = wd;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    set_m0('0, 32'h10, '0);
    @(negedge clk);
    check("rst_gnt0", bus.m0_gnt_o, 1'b0);
    check("rst_ram_en", bus.ram_en_o, 1'b0);
    check("rst_rvalid0", bus.m0_rvalid_o, 1'b0);
    step();
    rstn = 1'b1;

    // Both request right after reset: m0 first, then alternate.
    set_m0('0, 32'h0, '0);
    set_m1('0, 32'h0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("alt_gnt0", bus.m0_gnt_o, (i % 2) == 0);
      check("alt_gnt1", bus.m1_gnt_o, (i % 2) == 1);
      step();
    end
    idle();
    step();

    // m0 reads 0x10 alone.
    set_m0('0, 32'h10, '0);
    @(negedge clk);
    check("rd_gnt0", bus.m0_gnt_o, 1'b1);
    step();
    idle();
    @(negedge clk);
    check("rd_rvalid0", bus.m0_rvalid_o, 1'b1);
    check("rd_rdata0", bus.m0_rdata_o, 32'hDEAD_BEEF);
    check("rd_rvalid1", bus.m1_rvalid_o, 1'b0);
    step();

    // m1 partial write then m0 read-back.
    set_m1(4'b0011, 32'h20, 32'hCAFE_BABE);
    @(negedge clk);
    check("wr_gnt1", bus.m1_gnt_o, 1'b1);
    check("wr_ram_we", bus.ram_we_o, 4'b0011);
    step();
    idle();
    set_m0('0, 32'h20, '0);
    @(negedge clk);
    check("wr_no_rvalid1", bus.m1_rvalid_o, 1'b0);
    check("rb_gnt0", bus.m0_gnt_o, 1'b1);
    step();
    idle();
    @(negedge clk);
    check("rb_rvalid0", bus.m0_rvalid_o, 1'b1);
    check("rb_rdata0", bus.m0_rdata_o, 32'h0000_BABE);
    step();

    // Back-to-back reads with master switches.
    set_m0('0, 32'h4, '0);
    step();
    idle();
    set_m1('0, 32'h8, '0);
    @(negedge clk);
    check("b2b_rv0_a", bus.m0_rvalid_o, 1'b1);
    check("b2b_rd0_a", bus.m0_rdata_o, 32'hA0A0_0004);
    step();
    idle();
    set_m0('0, 32'hC, '0);
    @(negedge clk);
    check("b2b_rv1_b", bus.m1_rvalid_o, 1'b1);
    check("b2b_rd1_b", bus.m1_rdata_o, 32'hB0B0_0008);
    check("b2b_rv0_b", bus.m0_rvalid_o, 1'b0);
    step();
    idle();
    @(negedge clk);
    check("b2b_rv0_c", bus.m0_rvalid_o, 1'b1);
    check("b2b_rd0_c", bus.m0_rdata_o, 32'hC0C0_000C);
    step();

    // Reset right after a granted read drops the response.
    set_m0('0, 32'h10, '0);
    @(negedge clk);
    check("mr_gnt0", bus.m0_gnt_o, 1'b1);
    step();
    idle();
    rstn = 1'b0;
    @(negedge clk);
    check("mr_rvalid0_rst", bus.m0_rvalid_o, 1'b0);
    check("mr_rdata0_rst", bus.m0_rdata_o, 32'h0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_rvalid0_post", bus.m0_rvalid_o, 1'b0);
      step();
    end

`ifdef JEDRO_1_DMEM_ARB_LOCK_EN
    // Locked m0 holds the RAM for ML grants, then m1 gets in.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    set_m0('0, 32'h0, '0);
    bus.m0_lock_i = 1'b1;
    set_m1('0, 32'h4, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lk_gnt0", bus.m0_gnt_o, i < ML);
      check("lk_gnt1", bus.m1_gnt_o, i == ML);
      step();
    end
    idle();
    step();
`endif

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jedro_1_dmem_arbiter.md
Name: jedro_1_dmem_arbiter

Overview:
Two-master arbiter for the single-port byte-write data RAM of the jedro_1 core. Master 0 is the core load-store unit and master 1 is the debug/DMA port. The block shares the RAM between them with round-robin priority and routes the 1-cycle-latency read data back to whichever master issued the read. It sits between jedro_1_top's data_mem_if master side and bytewrite_ram_wrap.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
MAX_LOCK, 8, max consecutive grants held under lock (optional feature only)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
m0_req_i  in  1  master 0 access request
m0_we_i  in  DATA_WIDTH/8  master 0 byte write enables; all-zero means read
m0_addr_i  in  ADDR_WIDTH  master 0 address
m0_wdata_i  in  DATA_WIDTH  master 0 write data
m0_gnt_o  out  1  master 0 access accepted this cycle
m0_rvalid_o  out  1  master 0 read data valid
m0_rdata_o  out  DATA_WIDTH  master 0 read data
m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o  as master 0, for master 1
ram_en_o  out  1  RAM access strobe
ram_we_o  out  DATA_WIDTH/8  RAM byte write enables
ram_addr_o  out  ADDR_WIDTH  RAM address
ram_wdata_o  out  DATA_WIDTH  RAM write data
ram_rdata_i  in  DATA_WIDTH  RAM read data, valid 1 cycle after a read access

Behaviour:
- Clock is clk_i. Reset is rstn_i: asynchronous, active-low.
- Reset values:
  - gnt, rvalid and rdata outputs all 0.
  - ram_en_o, ram_we_o, ram_addr_o and ram_wdata_o all 0.
  - last_q = 1, so master 0 wins the first tie.
  - Response tracker rsp_valid_q = 0 and rsp_id_q = 0.
  - State = IDLE.
- Handshake:
  - A master holds req, we, addr and wdata stable until it sees gnt.
  - gnt is combinational in the same cycle as req; the access is complete on that cycle's rising edge.
  - At most one gnt is high per cycle.
- RAM mux:
  - ram_* are driven combinationally from the granted master.
  - With no grant, ram_en_o = 0 and all other ram_* outputs are 0.
- Arbitration:
  - Only one master requesting: that master is granted.
  - Both requesting: the master != last_q is granted.
  - last_q updates to the granted id on every grant.
- Read response:
  - On a granted read (we == 0): rsp_valid_q <= 1 and rsp_id_q <= id.
  - Next cycle the selected master gets rvalid = 1 and rdata = ram_rdata_i; the other master's rdata is 0.
  - Writes produce no rvalid.
  - Back-to-back reads, including a switch of master, have full throughput: one access per cycle with responses in order.
- FSM states: IDLE, OWN0, OWN1.
  - Without the optional feature, the FSM records the previous cycle's owner only: IDLE when there was no grant, OWNx when master x was granted.
- Reset mid-operation: a pending response is dropped and no rvalid is issued after reset release.

Optional Feature:
- Macro: JEDRO_1_DMEM_ARB_LOCK_EN.
- Defined:
  - Adds inputs m0_lock_i and m1_lock_i (1 bit each).
  - When master x is granted with lock_i = 1, the FSM enters OWNx and lock_cnt_q counts grants starting at 1.
  - While in OWNx and x holds req & lock, x is granted even if the other master requests.
  - lock_cnt_q increments per grant.
  - When lock_cnt_q reaches MAX_LOCK and the other master is requesting, the other master is granted and the FSM moves to IDLE or OWNy according to y's lock.
  - Dropping req or lock returns the FSM to IDLE with lock_cnt_q = 0, and normal round-robin resumes.
  - lock_cnt_q resets to 0.
- Undefined: lock ports, lock counter and lock transitions are absent; behaviour is pure round-robin.

Test Plan:
- m0 reads addr 0x10 alone (RAM holds 0xDEADBEEF) -> m0_gnt_o = 1 in cycle 0; m0_rvalid_o = 1 and m0_rdata_o = 0xDEADBEEF in cycle 1; m1_rvalid_o stays 0.
- Both request in the first cycle after reset -> m0 granted first, m1 next cycle; continuous requests from both then alternate 0,1,0,1.
- m1 writes 0xCAFEBABE to 0x20 with we = 4'b0011, then m0 reads 0x20 with the word previously 0 -> read returns 0x0000BABE; no rvalid for the write.
- Back-to-back reads m0@0x4, m1@0x8, m0@0xC -> three consecutive rvalid pulses, each routed to the correct master with the correct data.
- Assert rstn_i in the cycle after a granted m0 read -> no m0_rvalid_o after reset release; all outputs are 0 while in reset.
- With JEDRO_1_DMEM_ARB_LOCK_EN and MAX_LOCK = 4, m0 requests locked continuously while m1 requests -> m0 is granted 4 times, then m1 is granted on the 5th cycle.
